// File: rtl/common_pkg.sv
// Shared scheduler/LSU types and the warp LSU state encoding.
// Imported by warp_lsu and lsu_lane_align.
package common_pkg;

    typedef enum logic [1:0] {
        WARP_IDLE    = 2'd0,
        WARP_REQUEST = 2'd1,
        WARP_WAIT    = 2'd2,
        WARP_DONE    = 2'd3
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_DONE       = 2'd2
    } lsu_state_t;

    localparam logic [1:0] DS_WORD = 2'd0;
    localparam logic [1:0] DS_HALF = 2'd1;
    localparam logic [1:0] DS_BYTE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } lsu_int_state_t;

    function automatic lsu_state_t lsu_state_map(input lsu_int_state_t s);
        lsu_state_t r;
        case (s)
            S_IDLE:  r = LSU_IDLE;
            S_DONE:  r = LSU_DONE;
            default: r = LSU_REQUESTING;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Per-lane alignment: fault check, store byte placement in the line,
// and load extraction with sign/zero extension.
module lsu_lane_align
    import common_pkg::*;
#(
    parameter int LINE_BYTES = 16
) (
    input  logic [$clog2(LINE_BYTES)-1:0] offset,
    input  logic [1:0]                    size,
    input  logic                          usign,
    input  logic [31:0]                   rs2,
    input  logic [LINE_BYTES*8-1:0]       line,
    output logic                          fault,
    output logic [LINE_BYTES*8-1:0]       st_data,
    output logic [LINE_BYTES-1:0]         st_be,
    output logic [31:0]                   ld_data
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    int               n;
    logic [OFF_W-1:0] rel;
    logic [OFF_W-1:0] idx;
    logic [31:0]      raw;

    always_comb begin
        n     = 4;
        fault = 1'b0;
        case (size)
            DS_WORD: begin
                n     = 4;
                fault = (offset[1:0] != 2'b00);
            end
            DS_HALF: begin
                n     = 2;
                fault = offset[0];
            end
            DS_BYTE: begin
                n     = 1;
                fault = 1'b0;
            end
            default: begin
                n     = 1;
                fault = 1'b1;
            end
        endcase

        // Each line byte picks its source byte from rs2 by distance to offset
        st_data = '0;
        st_be   = '0;
        rel     = '0;
        for (int j = 0; j < LINE_BYTES; j++) begin
            rel = OFF_W'(j) - offset;
            if (!fault && int'(rel) < n) begin
                st_be[j]         = 1'b1;
                st_data[8*j +: 8] = rs2[8*rel[1:0] +: 8];
            end
        end

        raw = '0;
        idx = '0;
        for (int b = 0; b < 4; b++) begin
            idx            = offset + OFF_W'(b);
            raw[8*b +: 8]  = line[8*idx +: 8];
        end

        case (size)
            DS_BYTE: ld_data = usign ? {24'b0, raw[7:0]}
                                     : {{24{raw[7]}}, raw[7:0]};
            DS_HALF: ld_data = usign ? {16'b0, raw[15:0]}
                                     : {{16{raw[15]}}, raw[15:0]};
            default: ld_data = raw;
        endcase
    end

endmodule

// File: rtl/warp_lsu.sv
// Warp load/store unit: coalesces lanes hitting the same cache line
// into one line-wide request, serving groups in lowest-lane order.
module warp_lsu
    import common_pkg::*;
#(
    parameter int NUM_LANES            = 4,
    parameter int CACHE_LINE_BYTE_SIZE = 16,
    parameter int ADDR_W               = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  warp_state_t                       warp_state,
    input  logic [NUM_LANES-1:0]              active_mask,
    input  logic [NUM_LANES*32-1:0]           rs1,
    input  logic [NUM_LANES*32-1:0]           rs2,
    input  logic [NUM_LANES*32-1:0]           imm,
    input  logic [1:0]                        DataSize,
    input  logic                              DMemR_W,
    input  logic                              Usign,
    output logic                              mem_valid,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [CACHE_LINE_BYTE_SIZE*8-1:0] mem_data,
    output logic [CACHE_LINE_BYTE_SIZE-1:0]   mem_we,
    input  logic                              mem_resp_ready,
    input  logic [CACHE_LINE_BYTE_SIZE*8-1:0] mem_resp_data,
    output lsu_state_t                        lsu_state_out,
    output logic [NUM_LANES*32-1:0]           lsu_out,
    output logic [NUM_LANES-1:0]              lsu_fault_mask
);

    localparam int LB     = CACHE_LINE_BYTE_SIZE;
    localparam int LW     = LB * 8;
    localparam int OFF_W  = $clog2(LB);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    lsu_int_state_t state;

    logic [ADDR_W-1:0]      addr_in [NUM_LANES];
    logic [ADDR_W-1:0]      addr_q  [NUM_LANES];
    logic [NUM_LANES*32-1:0] rs2_q;
    logic [1:0]             size_q;
    logic                   we_q;
    logic                   usign_q;
    logic [NUM_LANES-1:0]   pending;
    logic [NUM_LANES-1:0]   grp_q;

    logic [OFF_W-1:0]       off_sel [NUM_LANES];
    logic [1:0]             size_sel;
    logic [NUM_LANES-1:0]   fault;
    logic [LW-1:0]          st_data [NUM_LANES];
    logic [LB-1:0]          st_be   [NUM_LANES];
    logic [31:0]            ld_data [NUM_LANES];

    logic [LANE_W-1:0]      leader;
    logic                   found;
    logic [NUM_LANES-1:0]   group;
    logic [LW-1:0]          grp_data;
    logic [LB-1:0]          grp_be;

    // Fault check sees live operands in IDLE, latched ones afterwards
    assign size_sel = (state == S_IDLE) ? DataSize : size_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign addr_in[g] = ADDR_W'(rs1[32*g +: 32] + imm[32*g +: 32]);
        assign off_sel[g] = (state == S_IDLE) ? addr_in[g][OFF_W-1:0]
                                              : addr_q[g][OFF_W-1:0];
        lsu_lane_align #(
            .LINE_BYTES(LB)
        ) u_align (
            .offset  (off_sel[g]),
            .size    (size_sel),
            .usign   (usign_q),
            .rs2     (rs2_q[32*g +: 32]),
            .line    (mem_resp_data),
            .fault   (fault[g]),
            .st_data (st_data[g]),
            .st_be   (st_be[g]),
            .ld_data (ld_data[g])
        );
    end

    always_comb begin
        leader = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pending[i] && !found) begin
                leader = LANE_W'(i);
                found  = 1'b1;
            end
        end
        group = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            group[i] = pending[i] &&
                (addr_q[i][ADDR_W-1:OFF_W] == addr_q[leader][ADDR_W-1:OFF_W]);
        end
        // Ascending lane order lets the higher lane overwrite overlaps
        grp_data = '0;
        grp_be   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < LB; j++) begin
                if (group[i] && st_be[i][j]) begin
                    grp_be[j]          = 1'b1;
                    grp_data[8*j +: 8] = st_data[i][8*j +: 8];
                end
            end
        end
    end

    assign lsu_state_out = lsu_state_map(state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            rs2_q          <= '0;
            size_q         <= '0;
            we_q           <= 1'b0;
            usign_q        <= 1'b0;
            pending        <= '0;
            grp_q          <= '0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            mem_we         <= '0;
            lsu_out        <= '0;
            lsu_fault_mask <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (warp_state == WARP_REQUEST) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            addr_q[i] <= addr_in[i];
                            if (active_mask[i] && fault[i]) begin
                                lsu_out[32*i +: 32] <= '0;
                            end
                        end
                        rs2_q          <= rs2;
                        size_q         <= DataSize;
                        we_q           <= DMemR_W;
                        usign_q        <= Usign;
                        lsu_fault_mask <= active_mask & fault;
                        pending        <= active_mask & ~fault;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pending == '0) begin
                        state <= S_DONE;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= {addr_q[leader][ADDR_W-1:OFF_W],
                                      {OFF_W{1'b0}}};
                        mem_we    <= we_q ? grp_be : '0;
                        mem_data  <= we_q ? grp_data : '0;
                        grp_q     <= group;
                        state     <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (mem_resp_ready) begin
                        mem_valid <= 1'b0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (grp_q[i] && !we_q) begin
                                lsu_out[32*i +: 32] <= ld_data[i];
                            end
                        end
                        pending <= pending & ~grp_q;
                        state   <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (warp_state == WARP_WAIT) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
